// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 console transmitter: TXDATA stores fill a small FIFO,
// and a serializer drains it onto tx with no gap between queued frames.
module mmio_uart_tx #(
   parameter int unsigned CLK_DIV    = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        tx,
   output logic        busy
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = $clog2(CLK_DIV);

   localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);
   localparam logic [PW-1:0] PTR_ONE     = PW'(1);
   localparam logic [BW-1:0] BAUD_LAST   = BW'(CLK_DIV - 1);
   localparam logic [BW-1:0] BAUD_ONE    = BW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   state_t        state;
   logic [BW-1:0] baud;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   logic          wr_hit;
   logic          rd_status;
   logic          full;
   logic          empty;
   logic          push;
   logic          drop;
   logic          pop;
   logic          baud_last;
   logic [31:0]   status;
   logic          unused_wdata;

   assign unused_wdata = ^bus_wdata[31:8];

   always_comb begin
      wr_hit    = bus_we && (bus_addr == BASE_ADDR);
      rd_status = bus_re && (bus_addr == STATUS_ADDR);
      full      = (count == FULL_COUNT);
      empty     = (count == '0);
      push      = wr_hit && !full;
      drop      = wr_hit && full;
      baud_last = (baud == BAUD_LAST);
      // The serializer pops from IDLE, or on the final STOP cycle to chain frames.
      pop       = !empty && ((state == IDLE) || ((state == STOP) && baud_last));
   end

   always_comb begin
      status            = '0;
      status[0]         = full;
      status[1]         = empty;
      status[2]         = (state != IDLE);
      status[3]         = overflow;
      status[8 +: CW]   = count;
   end

   assign busy = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus_wdata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A drop in the same cycle as a STATUS read wins, so it is not lost.
         if (drop) begin
            overflow <= 1'b1;
         end else if (rd_status) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         bus_rdata <= '0;
      end else if (rd_status) begin
         bus_rdata <= status;
      end else begin
         bus_rdata <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               baud <= '0;
               tx   <= 1'b1;
               if (pop) begin
                  shreg <= mem[rd_ptr];
                  tx    <= 1'b0;
                  state <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud    <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= shreg >> 1;
                     tx      <= shreg[1];
                  end
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (pop) begin
                     shreg <= mem[rd_ptr];
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud <= baud + BAUD_ONE;
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus
// hand sequences for frame timing, back-to-back frames, overflow and reset.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE   = 32'h1000_0000;
   localparam logic [31:0] STAT   = 32'h1000_0004;
   localparam logic [31:0] UNMAP  = 32'h1000_0008;

   logic        clk = 1'b0;
   logic        rst;
   logic        bus_we;
   logic        bus_re;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        tx;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rx_q[$];
   logic [7:0] rx_b;
   logic [7:0] exp_b[16];

   typedef struct {
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_tx;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[8];

   mmio_uart_tx #(
      .CLK_DIV   (4),
      .FIFO_DEPTH(8),
      .BASE_ADDR (32'h1000_0000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus_we   (bus_we),
      .bus_re   (bus_re),
      .bus_addr (bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .tx       (tx),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Checks n frames starting at the current sample (first start-bit cycle).
   task automatic run_frames(input int n);
      logic [7:0] b;
      int unsigned pos;
      logic e;
      for (int k = 0; k < n * 40; k++) begin
         b   = exp_b[k / 40];
         pos = (k % 40) / 4;
         if (pos == 0)      e = 1'b0;
         else if (pos == 9) e = 1'b1;
         else               e = b[pos - 1];
         chk($sformatf("frame_tx_k%0d", k), {31'b0, tx}, {31'b0, e});
         chk($sformatf("frame_busy_k%0d", k), {31'b0, busy}, 32'd1);
         step();
      end
      chk("end_busy", {31'b0, busy}, 32'd0);
      chk("end_tx", {31'b0, tx}, 32'd1);
      chk("rx_count", rx_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rx_q.size()) chk($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, exp_b[i]});
      end
   endtask

   // Line decoder: samples mid-bit, 4 cycles per bit.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst === 1'b1 && tx === 1'b0) begin
            repeat (2) begin @(posedge clk); #1; end
            for (int i = 0; i < 8; i++) begin
               repeat (4) begin @(posedge clk); #1; end
               rx_b[i] = tx;
            end
            repeat (4) begin @(posedge clk); #1; end
            rx_q.push_back(rx_b);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int lows;
      int busies;

      vecs[0] = '{1'b0, 1'b1, STAT,  32'h0,        32'h0000_0002, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 1'b0, UNMAP, 32'h0000_0011, 32'h0,         1'b1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, STAT,  32'h0000_00FF, 32'h0,         1'b1, 1'b0};
      vecs[3] = '{1'b0, 1'b1, UNMAP, 32'h0,        32'h0,         1'b1, 1'b0};
      vecs[4] = '{1'b0, 1'b1, STAT,  32'h0,        32'h0000_0002, 1'b1, 1'b0};
      vecs[5] = '{1'b0, 1'b1, BASE,  32'h0,        32'h0,         1'b1, 1'b0};
      vecs[6] = '{1'b1, 1'b1, STAT,  32'h0000_0042, 32'h0000_0002, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 1'b0, STAT,  32'h0,        32'h0,         1'b1, 1'b0};

      rst = 1'b0; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
      repeat (3) step();
      chk("reset_tx", {31'b0, tx}, 32'd1);
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_rdata", bus_rdata, 32'd0);
      rst = 1'b1;
      step();

      for (int i = 0; i < 8; i++) begin
         bus_we = vecs[i].we; bus_re = vecs[i].re;
         bus_addr = vecs[i].addr; bus_wdata = vecs[i].wdata;
         step();
         chk($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
         chk($sformatf("vec%0d_tx", i), {31'b0, tx}, {31'b0, vecs[i].exp_tx});
         chk($sformatf("vec%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
      end
      bus_we = 1'b0; bus_re = 1'b0;
      step();

      // Single byte 0x55
      rx_q.delete();
      exp_b[0] = 8'h55;
      bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'hFFFF_FF55;
      step();
      bus_we = 1'b0;
      chk("t0_tx_high", {31'b0, tx}, 32'd1);
      chk("t0_busy", {31'b0, busy}, 32'd1);
      step();
      run_frames(1);
      repeat (5) step();

      // Back-to-back 0xA5, 0x3C
      rx_q.delete();
      exp_b[0] = 8'hA5; exp_b[1] = 8'h3C;
      bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h0000_00A5;
      step();
      bus_wdata = 32'h0000_003C;
      step();
      bus_we = 1'b0;
      run_frames(2);
      repeat (5) step();

      // Overflow: 10 writes from empty, 9 accepted
      rx_q.delete();
      for (int i = 0; i < 10; i++) begin
         bus_we = 1'b1; bus_addr = BASE; bus_wdata = 32'h30 + i;
         step();
      end
      bus_we = 1'b0; bus_re = 1'b1; bus_addr = STAT;
      step();
      chk("ovf_status1", bus_rdata, 32'h0000_080D);
      step();
      chk("ovf_status2", bus_rdata, 32'h0000_0805);
      bus_re = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 1000) begin
         step();
         n++;
      end
      chk("ovf_drain_cycles", n, 350);
      repeat (3) step();
      chk("ovf_frames", rx_q.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (i < rx_q.size()) chk($sformatf("ovf_byte%0d", i), {24'b0, rx_q[i]}, 32'h30 + i);
      end

      // Reset during DATA bit 3 with 3 bytes queued
      repeat (5) step();
      bus_addr = BASE;
      for (int i = 0; i < 4; i++) begin
         bus_we = 1'b1; bus_wdata = 32'h11 * i;
         step();
      end
      bus_we = 1'b0;
      repeat (15) step();
      chk("pre_reset_tx_low", {31'b0, tx}, 32'd0);
      rst = 1'b0;
      step();
      chk("mid_reset_tx", {31'b0, tx}, 32'd1);
      chk("mid_reset_busy", {31'b0, busy}, 32'd0);
      chk("mid_reset_rdata", bus_rdata, 32'd0);
      rst = 1'b1; bus_re = 1'b1; bus_addr = STAT;
      step();
      chk("post_reset_status", bus_rdata, 32'h0000_0002);
      bus_re = 1'b0;
      lows = 0; busies = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tx !== 1'b1) lows++;
         if (busy !== 1'b0) busies++;
      end
      chk("post_reset_tx_lows", lows, 0);
      chk("post_reset_busy_cycles", busies, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped console transmitter on the CPU data bus. Program stores to a TXDATA register push bytes into a small FIFO. An 8N1 serializer drains the FIFO onto a single `tx` line. It is the CPU-side producer of the character stream that the simulation bench decodes and prints as program output; it replaces ad-hoc `$display` taps.

## Interface
- `CLK_DIV`, 4: clk cycles per UART bit; legal values are 2 or more.
- `FIFO_DEPTH`, 8: FIFO entries; legal values are 2, 4 or 8.
- `BASE_ADDR`, 32'h1000_0000: TXDATA address; STATUS is at BASE_ADDR+4.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `bus_we`  in  1  store strobe, sampled on posedge.
- `bus_re`  in  1  load strobe, sampled on posedge.
- `bus_addr`  in  32  byte address; full 32-bit compare.
- `bus_wdata`  in  32  store data; only [7:0] is used.
- `bus_rdata`  out  32  registered load data.
- `tx`  out  1  serial line, registered, idles high.
- `busy`  out  1  FIFO non-empty or frame in progress.

## Operation
- **Register map**
  - TXDATA (BASE_ADDR): write pushes wdata[7:0]; read returns 0.
  - STATUS (BASE_ADDR+4), read-only:
    - bit0 full (count == FIFO_DEPTH)
    - bit1 empty
    - bit2 serializer active (state != IDLE)
    - bit3 sticky overflow
    - [11:8] count
    - all other bits 0
  - Writes to STATUS are ignored. Unmapped addresses: no push, rdata 0.
- **Push rule**
  - A push is accepted only if count < FIFO_DEPTH at the start of the cycle.
  - A push while full is dropped and sets overflow, even if a pop happens in the same cycle.
  - Simultaneous accepted push and pop: count unchanged.
- **Overflow clear**: a STATUS read clears overflow on the same edge that captures it. The read returns 1; the next read returns 0 unless a new drop occurs.
- **FIFO**: circular buffer with wr/rd pointers of width log2(FIFO_DEPTH) that wrap modulo depth, plus a separate count register.
- **Serializer FSM**: IDLE, START, DATA, STOP.
  - Each bit period lasts exactly CLK_DIV cycles, timed by a baud counter that is reset on every state entry.
  - IDLE: tx=1. If FIFO is non-empty, pop into the shift register and go to START.
  - START: tx=0 for one bit period.
  - DATA: 8 bits, LSB first, shift-right per bit period; bit index 0..7; exit after bit 7 to STOP.
  - STOP: tx=1 for one bit period. On its last cycle:
    - FIFO non-empty: pop and go straight to START, so back-to-back frames have no gap.
    - Otherwise: go to IDLE.
- `busy` = !empty || state != IDLE. It is registered-equivalent, derived from registered state.

## Timing
- **Reset values**: tx=1, busy=0, bus_rdata=0, count=0, pointers 0, overflow=0, state IDLE, baud counter 0.
- **Reset mid-frame**: next cycle all of the above hold. FIFO contents are discarded and the frame is truncated, with no further low bits.
- **Load latency**: bus_rdata is valid the cycle after the edge sampling bus_re. It is 0 on any cycle not following a mapped read.
- **Push-to-line latency**: a push on edge t0 into an idle, empty block pops on edge t1, and tx falls after t1.
- **Frame length**: 10×CLK_DIV cycles. N queued bytes occupy exactly N×10×CLK_DIV consecutive cycles.
- **busy**: deasserts on the edge that enters IDLE with the FIFO empty.
- **Simultaneous we and re**: both are honoured independently.

## Test plan
- **Reset read**: after reset, read STATUS → bus_rdata 32'h0000_0002 one cycle later; tx=1, busy=0.
- **Single byte**: CLK_DIV=4, write 0x55 at t0 → tx holds each of the following for 4 cycles each, starting after t1:
  - low (start bit)
  - 1,0,1,0,1,0,1,0 (data, LSB first)
  - high (stop bit)
  - busy drops after 40 cycles of frame.
- **Back-to-back**: write 0xA5, 0x3C on consecutive cycles → 80 contiguous frame cycles with no idle gap; bits decode to 0xA5 then 0x3C.
- **Overflow**: 10 consecutive TXDATA writes from empty → 9 accepted, 1 dropped.
  - STATUS read then returns bit0=1, bit3=1, count=8.
  - An immediate second read shows bit3=0.
  - The line emits exactly 9 frames.
- **Unmapped/ignored accesses**: write to BASE_ADDR+8 and to STATUS → count stays 0, tx stays 1; read of BASE_ADDR+8 → 0.
- **Reset mid-operation**: assert rst during DATA bit 3 with 3 bytes queued → next cycle tx=1, busy=0, count=0; after release, no frame appears for 100 cycles.
